fp_div_issuer: RTL
==================

FP_DIV_ISSUER -- requirements
Module: fp_div_issuer

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, request FIFO and outstanding-tag FIFO depth (power of 2, 2..16)
- TAG_W, 4, request tag width
REQ-002 Ports SHALL be, one per line (clock and reset first):
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operand pair offered
- req_ready  out  1  request FIFO can accept
- req_dividend  in  32  IEEE-754 single dividend
- req_divisor  in  32  IEEE-754 single divisor
- req_tag  in  TAG_W  caller tag returned with result
- a_tvalid / a_tready / a_tdata  out/in/out  1/1/32  dividend AXI-stream channel to divider
- b_tvalid / b_tready / b_tdata  out/in/out  1/1/32  divisor AXI-stream channel to divider
- res_tvalid / res_tready / res_tdata  in/out/in  1/1/32  quotient channel from divider
- out_valid / out_ready  out/in  1/1  result handshake to caller
- out_data  out  32  quotient
- out_tag  out  TAG_W  tag of the request that produced out_data
- out_dbz  out  1  divisor was +/-0 (bits 30:0 all zero)
- outstanding  out  $clog2(DEPTH)+1  pairs issued but not yet returned
- err_orphan  out  1  sticky: result received with no outstanding tag

Function
REQ-003 Request FIFO: push on req_valid && req_ready; req_ready = !full; no same-cycle bypass when full, even if a pop occurs.
REQ-004 Entry stores {dividend, divisor, tag, dbz}; dbz computed at push from req_divisor[30:0]==0.
REQ-005 Head issue: when FIFO non-empty and tag FIFO not full, a_tvalid and b_tvalid SHALL assert with head data; a_tdata/b_tdata SHALL remain stable while the respective valid is high.
REQ-006 Channels SHALL complete independently: a_done/b_done flags set on their handshake; a valid drops after its own handshake and stays low until the head pops.
REQ-007 Head SHALL pop, and {tag, dbz} SHALL push into the tag FIFO, in the cycle the second of the two handshakes completes (or both in the same cycle); a_done/b_done clear in that cycle.
REQ-008 Earliest issue: a request pushed in cycle N SHALL present a/b_tvalid in cycle N+1; back-to-back pairs SHALL sustain one pair per cycle when both treadys are held high.
REQ-009 Issue SHALL stall (valids low, head not popped) while the tag FIFO holds DEPTH entries; a valid already high SHALL NOT drop before its handshake.
REQ-010 res_tready = !out_valid || out_ready (single output register, no skid).
REQ-011 On res_tvalid && res_tready with tag FIFO non-empty: load out_data/out_tag/out_dbz, pop the tag FIFO, set out_valid the next cycle.
REQ-012 On res_tvalid && res_tready with tag FIFO empty: drop the result, set err_orphan, leave out_* unchanged.
REQ-013 out_valid SHALL clear on out_ready unless a new result loads in the same cycle; out_* SHALL be stable while out_valid && !out_ready.
REQ-014 outstanding SHALL equal the tag FIFO count, updated for a simultaneous push and pop (net zero).
REQ-015 Results SHALL be returned strictly in issue order; no arithmetic is performed on data.

Reset
REQ-016 While reset is high: both FIFOs empty, a_done=b_done=0, a_tvalid=b_tvalid=0, req_ready=0, res_tready=0, out_valid=0, out_data=0, out_tag=0, out_dbz=0, outstanding=0, err_orphan=0.
REQ-017 Reset asserted mid-transfer SHALL discard all queued and in-flight bookkeeping; results arriving after reset are orphans (REQ-012).
REQ-018 In the first cycle after reset deasserts, req_ready=1 and res_tready=1.

Verification
REQ-019 Push {0x40C00000, 0x40000000, tag 3}, both treadys high, res returns 0x40400000 -> out_valid, out_data=0x40400000, out_tag=3, out_dbz=0.
REQ-020 a_tready high, b_tready low for 5 cycles -> a_tvalid drops after 1 cycle, b_tvalid held, head pops and outstanding becomes 1 only when b handshakes.
REQ-021 Push DEPTH+2 requests with res_tvalid low -> outstanding saturates at DEPTH, a/b valids low, req_ready low once request FIFO full; then return results -> tags out in push order.
REQ-022 Divisor 0x80000000 -> out_dbz=1 on its result.
REQ-023 res_tvalid pulse with outstanding=0 -> err_orphan=1 sticky, out_valid stays 0.
REQ-024 out_ready low with a result pending -> res_tready=0, out_* stable; reset asserted mid-burst -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/fp_div_issuer.sv
`default_nettype none
// ==== fp_div_issuer : issues FP divide operand pairs to a stream divider and returns ====
// ==== quotients in issue order with caller tag and divide-by-zero flag -- rev 1.0    ====
module fp_div_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_dividend,
  input  logic [31:0]              req_divisor,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     a_tvalid,
  input  logic                     a_tready,
  output logic [31:0]              a_tdata,
  output logic                     b_tvalid,
  input  logic                     b_tready,
  output logic [31:0]              b_tdata,
  input  logic                     res_tvalid,
  output logic                     res_tready,
  input  logic [31:0]              res_tdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_dbz,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_orphan
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [31:0]      r_req_a   [DEPTH];
  logic [31:0]      r_req_b   [DEPTH];
  logic [TAG_W-1:0] r_req_tag [DEPTH];
  logic             r_req_dbz [DEPTH];
  logic [c_aw-1:0]  r_req_wp, r_req_rp;
  logic [c_cw-1:0]  r_req_cnt;

  logic [TAG_W:0]   r_tag_mem [DEPTH];
  logic [c_aw-1:0]  r_tag_wp, r_tag_rp;
  logic [c_cw-1:0]  r_tag_cnt;

  logic             r_a_done, r_b_done;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_dbz;
  logic             r_err_orphan;

  logic w_req_full, w_req_empty, w_req_push, w_req_pop;
  logic w_tag_full, w_tag_empty, w_tag_pop;
  logic w_issue, w_a_hs, w_b_hs, w_pair_done, w_res_hs;

  assign w_req_full  = (r_req_cnt == c_full);
  assign w_req_empty = (r_req_cnt == '0);
  assign w_tag_full  = (r_tag_cnt == c_full);
  assign w_tag_empty = (r_tag_cnt == '0);

  // Ready outputs are gated by reset so nothing handshakes while reset is held.
  assign req_ready  = !reset && !w_req_full;
  assign res_tready = !reset && (!r_out_valid || out_ready);
  assign w_req_push = req_valid && req_ready;

  assign w_issue  = !w_req_empty && !w_tag_full;
  assign a_tvalid = w_issue && !r_a_done;
  assign b_tvalid = w_issue && !r_b_done;
  assign a_tdata  = r_req_a[r_req_rp];
  assign b_tdata  = r_req_b[r_req_rp];
  assign w_a_hs   = a_tvalid && a_tready;
  assign w_b_hs   = b_tvalid && b_tready;

  // The pair retires on whichever handshake completes second (or both together).
  assign w_pair_done = w_issue && (r_a_done || w_a_hs) && (r_b_done || w_b_hs);
  assign w_req_pop   = w_pair_done;

  assign w_res_hs  = res_tvalid && res_tready;
  assign w_tag_pop = w_res_hs && !w_tag_empty;

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_tag     = r_out_tag;
  assign out_dbz     = r_out_dbz;
  assign outstanding = r_tag_cnt;
  assign err_orphan  = r_err_orphan;

  always_ff @(posedge clock) begin
    if (w_req_push) begin
      r_req_a[r_req_wp]   <= req_dividend;
      r_req_b[r_req_wp]   <= req_divisor;
      r_req_tag[r_req_wp] <= req_tag;
      r_req_dbz[r_req_wp] <= (req_divisor[30:0] == 31'd0);
    end
    if (w_pair_done) begin
      r_tag_mem[r_tag_wp] <= {r_req_tag[r_req_rp], r_req_dbz[r_req_rp]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_wp  <= '0;
      r_req_rp  <= '0;
      r_req_cnt <= '0;
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_tag_cnt <= '0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
    end else begin
      if (w_req_push) r_req_wp <= r_req_wp + c_ptr_one;
      if (w_req_pop)  r_req_rp <= r_req_rp + c_ptr_one;
      case ({w_req_push, w_req_pop})
        2'b10:   r_req_cnt <= r_req_cnt + c_cnt_one;
        2'b01:   r_req_cnt <= r_req_cnt - c_cnt_one;
        default: r_req_cnt <= r_req_cnt;
      endcase

      if (w_pair_done) r_tag_wp <= r_tag_wp + c_ptr_one;
      if (w_tag_pop)   r_tag_rp <= r_tag_rp + c_ptr_one;
      case ({w_pair_done, w_tag_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + c_cnt_one;
        2'b01:   r_tag_cnt <= r_tag_cnt - c_cnt_one;
        default: r_tag_cnt <= r_tag_cnt;
      endcase

      if (w_pair_done) begin
        r_a_done <= 1'b0;
        r_b_done <= 1'b0;
      end else begin
        if (w_a_hs) r_a_done <= 1'b1;
        if (w_b_hs) r_b_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
      r_out_dbz    <= 1'b0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_tag_pop) begin
        r_out_valid              <= 1'b1;
        r_out_data               <= res_tdata;
        {r_out_tag, r_out_dbz}   <= r_tag_mem[r_tag_rp];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_res_hs && w_tag_empty) r_err_orphan <= 1'b1;
    end
  end

endmodule
`default_nettype wire
